// File: rtl/imm_ext_pkg.sv
// Shared mode codes and occupancy encoding for the immediate-extension pipeline.
package imm_ext_pkg;

    typedef enum logic [2:0] {
        MODE_IMM5S = 3'd0,
        MODE_IMM5Z = 3'd1,
        MODE_IMM8S = 3'd2,
        MODE_IMM8Z = 3'd3,
        MODE_DIS11 = 3'd4,
        MODE_SHL8  = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: field + mode -> WIDTH-bit immediate and illegal-mode flag.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FIELD_W = 11
) (
    input  logic [FIELD_W-1:0] in_field,
    input  logic [2:0]         in_mode,
    output logic [WIDTH-1:0]   imm,
    output logic               err
);

    always_comb begin
        imm = '0;
        err = 1'b0;
        case (in_mode)
            MODE_IMM5S: imm = {{(WIDTH-5){in_field[4]}}, in_field[4:0]};
            MODE_IMM5Z: imm = {{(WIDTH-5){1'b0}}, in_field[4:0]};
            MODE_IMM8S: imm = {{(WIDTH-8){in_field[7]}}, in_field[7:0]};
            MODE_IMM8Z: imm = {{(WIDTH-8){1'b0}}, in_field[7:0]};
            MODE_DIS11: imm = {{(WIDTH-11){in_field[10]}}, in_field[10:0]};
            MODE_SHL8:  imm[15:8] = in_field[7:0];
            default:    err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with valid/ready handshake and flush.
// IMM_EXTEND_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FIELD_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIELD_W-1:0] in_field,
    input  logic [2:0]         in_mode,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_imm,
    output logic               out_err
);

    logic [WIDTH-1:0] core_imm;
    logic             core_err;
    logic             accept;
    logic             consume;
    logic             rst_done_q;
    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic             err_q, err_d;

    imm_ext_core #(
        .WIDTH   (WIDTH),
        .FIELD_W (FIELD_W)
    ) u_core (
        .in_field (in_field),
        .in_mode  (in_mode),
        .imm      (core_imm),
        .err      (core_err)
    );

    assign out_valid = (occ_q != OCC_EMPTY);
    assign out_imm   = imm_q;
    assign out_err   = err_q;
    assign consume   = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

`ifdef IMM_EXTEND_SKID_EN
    logic [WIDTH-1:0] skid_imm_q, skid_imm_d;
    logic             skid_err_q, skid_err_d;

    always_comb begin
        in_ready = rst_done_q && !flush && (occ_q != OCC_TWO);
    end

    // imm_q is always the head; the skid slot only fills while the head stalls.
    always_comb begin
        occ_d      = occ_q;
        imm_d      = imm_q;
        err_d      = err_q;
        skid_imm_d = skid_imm_q;
        skid_err_d = skid_err_q;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_d = OCC_ONE;
                        imm_d = core_imm;
                        err_d = core_err;
                    end
                end
                OCC_ONE: begin
                    if (accept && consume) begin
                        imm_d = core_imm;
                        err_d = core_err;
                    end else if (accept) begin
                        occ_d      = OCC_TWO;
                        skid_imm_d = core_imm;
                        skid_err_d = core_err;
                    end else if (consume) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (consume) begin
                        occ_d = OCC_ONE;
                        imm_d = skid_imm_q;
                        err_d = skid_err_q;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_imm_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            skid_imm_q <= skid_imm_d;
            skid_err_q <= skid_err_d;
        end
    end
`else
    always_comb begin
        in_ready = rst_done_q && !flush && (!out_valid || out_ready);
    end

    always_comb begin
        occ_d = occ_q;
        imm_d = imm_q;
        err_d = err_q;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else if (accept) begin
            occ_d = OCC_ONE;
            imm_d = core_imm;
            err_d = core_err;
        end else if (consume) begin
            occ_d = OCC_EMPTY;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q <= 1'b0;
            occ_q      <= OCC_EMPTY;
            imm_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            occ_q      <= occ_d;
            imm_q      <= imm_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: output datapath width, legal range 16..64.
REQ-002 SHALL have parameter FIELD_W, default 11: instruction immediate field width, fixed at 11 in this generation.
REQ-003 SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1: the upstream field and mode are valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts a transfer this cycle.
REQ-007 SHALL have port in_field, input, FIELD_W: the raw instruction immediate bits [10:0].
REQ-008 SHALL have port in_mode, input, 3: the extension mode code.
REQ-009 SHALL have port flush, input, 1: discard all held entries.
REQ-010 SHALL have port out_valid, output, 1: out_imm holds a result.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port out_imm, output, WIDTH: the extended immediate.
REQ-013 SHALL have port out_err, output, 1: the result came from an illegal mode; qualified by out_valid.

Function
REQ-014 SHALL implement mode 0, IMM5S: sign-extend in_field[4:0] to WIDTH.
REQ-015 SHALL implement mode 1, IMM5Z: zero-extend in_field[4:0] to WIDTH.
REQ-016 SHALL implement mode 2, IMM8S: sign-extend in_field[7:0] to WIDTH.
REQ-017 SHALL implement mode 3, IMM8Z: zero-extend in_field[7:0] to WIDTH.
REQ-018 SHALL implement mode 4, DIS11: sign-extend in_field[10:0] to WIDTH.
REQ-019 SHALL implement mode 5, SHL8: place in_field[7:0] at bits [15:8], zeros elsewhere.
REQ-020 SHALL treat modes 6 and 7 as illegal: out_imm = 0, out_err = 1.
REQ-021 SHALL define a transfer as in_valid && in_ready at a rising edge, with a result latency of exactly 1 cycle: the registered result appears on the following cycle.
REQ-022 SHALL hold out_imm and out_err stable while out_valid && !out_ready (stall).
REQ-023 SHALL, on simultaneous output consume and input accept, replace the output register with the new result and keep out_valid = 1 with no bubble.
REQ-024 SHALL, on flush, clear out_valid and all buffered entries at the next edge and ignore any same-cycle input; in_ready SHALL be 0 during flush.
REQ-025 SHALL preserve results in order; none SHALL be dropped or duplicated.
REQ-026 SHALL keep an internal occupancy state EMPTY/ONE/TWO (TWO reachable only with the skid buffer) with these transitions:
- accept only: +1
- consume only: -1
- both: unchanged
- flush: EMPTY

Reset
REQ-027 SHALL, while rst_n = 0, immediately force out_valid = 0, out_imm = 0, out_err = 0 and occupancy EMPTY, independent of clk.
REQ-028 SHALL hold in_ready = 0 during reset.
REQ-029 SHALL raise in_ready on the first edge after rst_n deasserts.
REQ-030 SHALL abandon any in-flight entry if reset asserts mid-stall.

Configuration
REQ-031 SHALL use macro IMM_EXTEND_SKID_EN to select the buffering scheme.
REQ-032 SHALL, when the macro is defined:
- add a 2-entry skid buffer
- drive in_ready from registered state only (in_ready = occupancy != TWO)
- have no combinational path from out_ready to in_ready
REQ-033 SHALL, when the macro is undefined:
- use a single output register
- drive in_ready = !out_valid || out_ready, a combinational path
- never reach occupancy TWO

Structure
REQ-034 SHALL place the mode code constants (IMM5S..SHL8) and the occupancy state enum in shared package imm_ext_pkg.
REQ-035 SHALL implement the pure combinational extension in sub-module imm_ext_core (in_field, in_mode -> imm, err), parametrised by WIDTH.
REQ-036 SHALL keep all sequential logic in imm_extend_pipe.

Verification
REQ-037 SHALL cover mode sweep, WIDTH=16:
- field 0x01F mode 0 -> 0xFFFF
- mode 1 -> 0x001F
- field 0x080 mode 2 -> 0xFF80
- mode 3 -> 0x0080
- field 0x400 mode 4 -> 0xFC00
- field 0x0AB mode 5 -> 0xAB00
REQ-038 SHALL cover illegal mode: mode 6 with field 0x7FF -> out_imm 0x0000, out_err 1 one cycle later.
REQ-039 SHALL cover stall:
- stimulus: out_ready low 3 cycles with in_valid held
- response: out_imm stable, no loss
- without skid: in_ready 0 after the first accept
- with skid: in_ready 0 after the second accept
REQ-040 SHALL cover back-to-back: 8 consecutive transfers with out_ready=1 -> 8 results in order, out_valid continuously 1 from cycle 2 to cycle 9.
REQ-041 SHALL cover flush while occupancy ONE/TWO -> out_valid 0 next cycle; the same-cycle input never emerges.
REQ-042 SHALL cover reset: rst_n pulsed low mid-stall -> out_valid 0 immediately, in_ready 1 one edge after release.
